// File: rtl/apb_fsm_controller_if.sv
// AHB-to-APB bridge control-stage signal bundle: pipelined AHB inputs in, APB request fields out.
interface apb_fsm_controller_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SLAVES = 3
);
    logic              valid;
    logic [WIDTH-1:0]  Haddr;
    logic [WIDTH-1:0]  Haddr1;
    logic [WIDTH-1:0]  Haddr2;
    logic [WIDTH-1:0]  Hwdata;
    logic              Hwrite;
    logic              Hwritereg;
    logic [SLAVES-1:0] tempselx;
    logic [WIDTH-1:0]  Prdata_in;
    logic [WIDTH-1:0]  Paddr_in;
    logic              Pwrite_in;
    logic [WIDTH-1:0]  Pwdata_in;
    logic [SLAVES-1:0] Pselx_in;
    logic              Penable_in;
    logic              Hreadyout;
    logic [WIDTH-1:0]  Hrdata;

    // Controller view: sequences the APB phases.
    modport master (
        input  valid, Haddr, Haddr1, Haddr2, Hwdata, Hwrite, Hwritereg, tempselx, Prdata_in,
        output Paddr_in, Pwrite_in, Pwdata_in, Pselx_in, Penable_in, Hreadyout, Hrdata
    );

    // Surrounding-stage view: supplies AHB pipeline, consumes APB request.
    modport slave (
        output valid, Haddr, Haddr1, Haddr2, Hwdata, Hwrite, Hwritereg, tempselx, Prdata_in,
        input  Paddr_in, Pwrite_in, Pwdata_in, Pselx_in, Penable_in, Hreadyout, Hrdata
    );
endinterface

// File: rtl/apb_fsm_controller.sv
// AHB-to-APB bridge control FSM: turns pipelined AHB transfers into APB SETUP/ENABLE phases.
module apb_fsm_controller #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SLAVES = 3
) (
    input  logic                 Hclk,
    input  logic                 Hresetn,
    apb_fsm_controller_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RENABLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WRITEP,
        ST_WENABLE,
        ST_WENABLEP
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    paddr_q, paddr_d;
    logic [WIDTH-1:0]    pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic [SLAVES-1:0]   psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                hready_q, hready_d;

    // State and APB request registers; reset aborts any transfer in flight.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            hready_q  <= hready_d;
        end
    end

    // Next state and next APB outputs; address/data/direction hold unless a SETUP loads them.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        hready_d  = hready_q;

        case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (bus.valid && !bus.Hwrite) begin
                    state_d   = ST_READ;
                    paddr_d   = bus.Haddr;
                    pwrite_d  = 1'b0;
                    psel_d    = bus.tempselx;
                    penable_d = 1'b0;
                    hready_d  = 1'b0;
                end else begin
                    // Writes wait a cycle here so Hwdata reaches its data phase.
                    state_d   = bus.valid ? ST_WWAIT : ST_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    hready_d  = 1'b1;
                end
            end

            ST_READ: begin
                state_d   = ST_RENABLE;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end

            ST_WWAIT: begin
                state_d   = bus.valid ? ST_WRITEP : ST_WRITE;
                paddr_d   = bus.Haddr1;
                pwdata_d  = bus.Hwdata;
                pwrite_d  = 1'b1;
                psel_d    = bus.tempselx;
                penable_d = 1'b0;
                hready_d  = 1'b0;
            end

            ST_WRITE: begin
                state_d   = bus.valid ? ST_WENABLEP : ST_WENABLE;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end

            ST_WRITEP: begin
                state_d   = ST_WENABLEP;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end

            ST_WENABLEP: begin
                if (bus.Hwritereg) begin
                    // Pipelined write: its address is now two cycles old.
                    state_d   = bus.valid ? ST_WRITEP : ST_WRITE;
                    paddr_d   = bus.Haddr2;
                    pwdata_d  = bus.Hwdata;
                    pwrite_d  = 1'b1;
                    psel_d    = bus.tempselx;
                    penable_d = 1'b0;
                    hready_d  = 1'b0;
                end else begin
                    state_d   = ST_READ;
                    paddr_d   = bus.Haddr;
                    pwrite_d  = 1'b0;
                    psel_d    = bus.tempselx;
                    penable_d = 1'b0;
                    hready_d  = 1'b0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end
        endcase
    end

    // Registered outputs onto the bundle; read data passes straight through.
    assign bus.Paddr_in   = paddr_q;
    assign bus.Pwdata_in  = pwdata_q;
    assign bus.Pwrite_in  = pwrite_q;
    assign bus.Pselx_in   = psel_q;
    assign bus.Penable_in = penable_q;
    assign bus.Hreadyout  = hready_q;
    assign bus.Hrdata     = bus.Prdata_in;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed vector bench for apb_fsm_controller.
module tb_apb_fsm_controller;

    logic Hclk;
    logic Hresetn;
    int   total;
    int   bad;

    apb_fsm_controller_if #(.WIDTH(32), .SLAVES(3)) bus ();

    apb_fsm_controller #(.WIDTH(32), .SLAVES(3)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct {
        logic        valid;
        logic        hwrite;
        logic        hwritereg;
        logic [2:0]  sel;
        logic [31:0] haddr;
        logic [31:0] haddr1;
        logic [31:0] haddr2;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic        e_pwrite;
        logic [2:0]  e_psel;
        logic        e_pen;
        logic        e_hready;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(
        input logic v, input logic hw, input logic hwr, input logic [2:0] s,
        input logic [31:0] ha, input logic [31:0] ha1, input logic [31:0] ha2,
        input logic [31:0] wd, input logic [31:0] prd,
        input logic [31:0] ep, input logic [31:0] ew, input logic er,
        input logic [2:0] es, input logic ee, input logic eh);
        vec_t r;
        r.valid = v;   r.hwrite = hw;  r.hwritereg = hwr; r.sel = s;
        r.haddr = ha;  r.haddr1 = ha1; r.haddr2 = ha2;
        r.hwdata = wd; r.prdata = prd;
        r.e_paddr = ep; r.e_pwdata = ew; r.e_pwrite = er;
        r.e_psel = es;  r.e_pen = ee;    r.e_hready = eh;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        bus.valid     = r.valid;
        bus.Hwrite    = r.hwrite;
        bus.Hwritereg = r.hwritereg;
        bus.tempselx  = r.sel;
        bus.Haddr     = r.haddr;
        bus.Haddr1    = r.haddr1;
        bus.Haddr2    = r.haddr2;
        bus.Hwdata    = r.hwdata;
        bus.Prdata_in = r.prdata;
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic chk_idle_reset(input string nm);
        chk({nm, " hready"}, 32'(bus.Hreadyout), 32'd1);
        chk({nm, " psel"},   32'(bus.Pselx_in),  32'd0);
        chk({nm, " pen"},    32'(bus.Penable_in), 32'd0);
        chk({nm, " paddr"},  bus.Paddr_in,       32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(mkv(0,0,0,3'b000,0,0,0,0,0, 0,0,0,3'b000,0,1));
        Hresetn = 1'b0;

        // Reset held with random inputs: outputs must stay at reset values.
        for (int i = 0; i < 4; i++) begin
            bus.valid     = 1'($urandom);
            bus.Hwrite    = 1'($urandom);
            bus.Hwritereg = 1'($urandom);
            bus.tempselx  = 3'($urandom);
            bus.Haddr     = $urandom;
            bus.Haddr1    = $urandom;
            bus.Haddr2    = $urandom;
            bus.Hwdata    = $urandom;
            tick();
            chk_idle_reset($sformatf("rst%0d", i));
        end
        drive(mkv(0,0,0,3'b000,0,0,0,0,0, 0,0,0,3'b000,0,1));
        @(negedge Hclk);
        Hresetn = 1'b1;
        #1;

        //          v hw hr sel     haddr         haddr1        haddr2        hwdata        prdata        e_paddr       e_pwdata      wr sel    en rdy
        vecs.push_back(mkv(0,0,0,3'b000,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0,3'b000,0,1));
        // single read
        vecs.push_back(mkv(1,0,0,3'b001,32'h8000_0010,32'h0,        32'h0,        32'h0,        32'h0,        32'h8000_0010,32'h0,        0,3'b001,0,0));
        vecs.push_back(mkv(0,0,0,3'b001,32'h0,        32'h0,        32'h0,        32'h0,        32'hDEAD_BEEF,32'h8000_0010,32'h0,        0,3'b001,1,1));
        vecs.push_back(mkv(0,0,0,3'b000,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h8000_0010,32'h0,        0,3'b000,0,1));
        // single write
        vecs.push_back(mkv(1,1,0,3'b010,32'h8400_0020,32'h0,        32'h0,        32'h0,        32'h0,        32'h8000_0010,32'h0,        0,3'b000,0,1));
        vecs.push_back(mkv(0,0,1,3'b010,32'h0,        32'h8400_0020,32'h0,        32'h1234_5678,32'h0,        32'h8400_0020,32'h1234_5678,1,3'b010,0,0));
        vecs.push_back(mkv(0,0,0,3'b010,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h8400_0020,32'h1234_5678,1,3'b010,1,1));
        vecs.push_back(mkv(0,0,0,3'b000,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h8400_0020,32'h1234_5678,1,3'b000,0,1));
        // back-to-back writes
        vecs.push_back(mkv(1,1,0,3'b001,32'h8000_0000,32'h0,        32'h0,        32'h0,        32'h0,        32'h8400_0020,32'h1234_5678,1,3'b000,0,1));
        vecs.push_back(mkv(1,1,1,3'b001,32'h8000_0004,32'h8000_0000,32'h0,        32'h11,       32'h0,        32'h8000_0000,32'h11,       1,3'b001,0,0));
        vecs.push_back(mkv(0,0,1,3'b001,32'h0,        32'h8000_0004,32'h8000_0000,32'h22,       32'h0,        32'h8000_0000,32'h11,       1,3'b001,1,1));
        vecs.push_back(mkv(0,0,1,3'b001,32'h0,        32'h0,        32'h8000_0004,32'h22,       32'h0,        32'h8000_0004,32'h22,       1,3'b001,0,0));
        vecs.push_back(mkv(0,0,0,3'b001,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h8000_0004,32'h22,       1,3'b001,1,1));
        vecs.push_back(mkv(0,0,0,3'b000,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h8000_0004,32'h22,       1,3'b000,0,1));
        // write then read
        vecs.push_back(mkv(1,1,0,3'b100,32'h8800_0000,32'h0,        32'h0,        32'h0,        32'h0,        32'h8000_0004,32'h22,       1,3'b000,0,1));
        vecs.push_back(mkv(1,0,1,3'b100,32'h8800_0008,32'h8800_0000,32'h0,        32'hAA,       32'h0,        32'h8800_0000,32'hAA,       1,3'b100,0,0));
        vecs.push_back(mkv(0,0,0,3'b100,32'h8800_0008,32'h0,        32'h0,        32'h0,        32'h0,        32'h8800_0000,32'hAA,       1,3'b100,1,1));
        vecs.push_back(mkv(0,0,0,3'b100,32'h8800_0008,32'h0,        32'h0,        32'h0,        32'h0,        32'h8800_0008,32'hAA,       0,3'b100,0,0));
        vecs.push_back(mkv(0,0,0,3'b100,32'h0,        32'h0,        32'h0,        32'h0,        32'hCAFE_F00D,32'h8800_0008,32'hAA,       0,3'b100,1,1));
        // back-to-back reads straight out of RENABLE
        vecs.push_back(mkv(1,0,0,3'b010,32'h8400_0040,32'h0,        32'h0,        32'h0,        32'h0,        32'h8400_0040,32'hAA,       0,3'b010,0,0));
        vecs.push_back(mkv(1,0,0,3'b010,32'h8400_0044,32'h0,        32'h0,        32'h0,        32'h1357_9BDF,32'h8400_0040,32'hAA,       0,3'b010,1,1));
        vecs.push_back(mkv(0,0,0,3'b000,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h8400_0040,32'hAA,       0,3'b000,0,1));
        // new transfer arriving during WRITE goes via WENABLEP
        vecs.push_back(mkv(1,1,0,3'b001,32'h8000_0100,32'h0,        32'h0,        32'h0,        32'h0,        32'h8400_0040,32'hAA,       0,3'b000,0,1));
        vecs.push_back(mkv(0,0,1,3'b001,32'h0,        32'h8000_0100,32'h0,        32'h55,       32'h0,        32'h8000_0100,32'h55,       1,3'b001,0,0));
        vecs.push_back(mkv(1,0,0,3'b001,32'h8000_0200,32'h0,        32'h0,        32'h0,        32'h0,        32'h8000_0100,32'h55,       1,3'b001,1,1));
        vecs.push_back(mkv(0,0,0,3'b001,32'h8000_0200,32'h0,        32'h0,        32'h0,        32'h0,        32'h8000_0200,32'h55,       0,3'b001,0,0));
        vecs.push_back(mkv(0,0,0,3'b001,32'h0,        32'h0,        32'h0,        32'h0,        32'h0BAD_F00D,32'h8000_0200,32'h55,       0,3'b001,1,1));
        vecs.push_back(mkv(0,0,0,3'b000,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h8000_0200,32'h55,       0,3'b000,0,1));
        // upstream decode error: zero select still sequences
        vecs.push_back(mkv(1,0,0,3'b000,32'h9000_0000,32'h0,        32'h0,        32'h0,        32'h0,        32'h9000_0000,32'h55,       0,3'b000,0,0));
        vecs.push_back(mkv(0,0,0,3'b000,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h9000_0000,32'h55,       0,3'b000,1,1));
        vecs.push_back(mkv(0,0,0,3'b000,32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h9000_0000,32'h55,       0,3'b000,0,1));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("row%0d paddr", i),  bus.Paddr_in,              vecs[i].e_paddr);
            chk($sformatf("row%0d pwdata", i), bus.Pwdata_in,             vecs[i].e_pwdata);
            chk($sformatf("row%0d pwrite", i), 32'(bus.Pwrite_in),        32'(vecs[i].e_pwrite));
            chk($sformatf("row%0d psel", i),   32'(bus.Pselx_in),         32'(vecs[i].e_psel));
            chk($sformatf("row%0d pen", i),    32'(bus.Penable_in),       32'(vecs[i].e_pen));
            chk($sformatf("row%0d hready", i), 32'(bus.Hreadyout),        32'(vecs[i].e_hready));
            chk($sformatf("row%0d hrdata", i), bus.Hrdata,                vecs[i].prdata);
        end

        // Reset asserted mid-cycle while in RENABLE aborts the ENABLE phase at once.
        drive(mkv(1,0,0,3'b001,32'hA000_0000,0,0,0,0, 0,0,0,3'b000,0,1));
        tick();
        chk("abort setup psel", 32'(bus.Pselx_in), 32'd1);
        drive(mkv(0,0,0,3'b000,0,0,0,0,0, 0,0,0,3'b000,0,1));
        tick();
        chk("abort enable pen", 32'(bus.Penable_in), 32'd1);
        #2;
        Hresetn = 1'b0;
        #1;
        chk("abort pen",    32'(bus.Penable_in), 32'd0);
        chk("abort psel",   32'(bus.Pselx_in),   32'd0);
        chk("abort hready", 32'(bus.Hreadyout),  32'd1);
        chk("abort paddr",  bus.Paddr_in,        32'd0);
        chk("abort pwdata", bus.Pwdata_in,       32'd0);
        tick();
        chk_idle_reset("abort hold");
        @(negedge Hclk);
        Hresetn = 1'b1;
        tick();
        chk_idle_reset("post-rst idle");
        // Must be in IDLE: a read request produces a fresh SETUP.
        drive(mkv(1,0,0,3'b010,32'hB000_0000,0,0,0,0, 0,0,0,3'b000,0,1));
        tick();
        chk("post-rst paddr",  bus.Paddr_in,        32'hB000_0000);
        chk("post-rst psel",   32'(bus.Pselx_in),   32'd2);
        chk("post-rst pen",    32'(bus.Penable_in), 32'd0);
        chk("post-rst hready", 32'(bus.Hreadyout),  32'd0);
        drive(mkv(0,0,0,3'b000,0,0,0,0,0, 0,0,0,3'b000,0,1));
        tick();
        chk("post-rst enable pen", 32'(bus.Penable_in), 32'd1);
        chk("post-rst enable rdy", 32'(bus.Hreadyout),  32'd1);
        tick();
        chk("post-rst final pen",  32'(bus.Penable_in), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
